// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the round-robin UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4,
    ABORT     = 3'd5
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART transmitter signals of the arbiter; master is the arbiter side.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic [IDX_W-1:0]          owner;
  logic                      active;
  logic                      timeout_err;

  modport master (
    input  req, req_data, tx_busy, tx_done,
    output gnt, tx_start, tx_data, owner, active, timeout_err
  );

  modport slave (
    output req, req_data, tx_busy, tx_done,
    input  gnt, tx_start, tx_data, owner, active, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     ofs;
  logic [IDX_W:0]       sum;

  // Rotating the doubled vector puts rr_ptr at bit 0.
  assign dbl     = {req_i, req_i};
  assign rot     = NUM_REQ'(dbl >> rr_ptr_i);
  assign valid_o = |req_i;

  always_comb begin
    ofs = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) ofs = IDX_W'(i);
    end
    sum = {1'b0, rr_ptr_i} + {1'b0, ofs};
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    winner_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; grant, start handshake,
// completion wait and watchdog abort.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             srst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                active_q, active_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [DATA_W-1:0]   pick_data;
  logic                cnt_expired;
  logic [IDX_W-1:0]    owner_inc;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign cnt_expired = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));
  assign owner_inc   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Completion always beats busy and watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pick_valid) state_d = LOAD;
      LOAD:      state_d = START;
      START: begin
        if (bus.tx_done)      state_d = DONE;
        else if (bus.tx_busy) state_d = WAIT_DONE;
        else if (cnt_expired) state_d = ABORT;
      end
      WAIT_DONE: begin
        if (bus.tx_done)      state_d = DONE;
        else if (cnt_expired) state_d = ABORT;
      end
      DONE:      state_d = IDLE;
      ABORT:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    gnt_d         = '0;
    tx_data_d     = tx_data_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    tx_start_d    = (state_d == START);
    timeout_err_d = (state_d == ABORT);
    active_d      = (state_d != IDLE);

    if (state_q == IDLE && pick_valid) begin
      gnt_d[pick_idx] = 1'b1;
      tx_data_d       = pick_data;
      owner_d         = pick_idx;
    end

    case (state_q)
      LOAD:             cnt_d = '0;
      START, WAIT_DONE: if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      DONE, ABORT:      rr_ptr_d = owner_inc;
      default:          ;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      gnt_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      gnt_q         <= gnt_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      active_q      <= active_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.owner       = owner_q;
  assign bus.active      = active_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one long-timeout instance for protocol
// scenarios and one TIMEOUT_CYC=20 instance for the watchdog.
module tb_uart_tx_arbiter;

  logic clk;
  logic srst;
  int   total;
  int   bad;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus_t ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(65535)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(20)) dut_t (
    .clk  (clk),
    .srst (srst),
    .bus  (bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits up to 10 cycles for any grant on the main instance; -1 on expiry.
  task automatic wait_gnt(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Well-behaved transmitter: called in LOAD, returns in DONE.
  task automatic ack_xfer();
    @(negedge clk);
    bus.tx_busy = 1'b1;
    @(negedge clk);
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.tx_start, bus.tx_data, bus.owner, bus.active, bus.timeout_err} !== 17'h0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b start=%b data=%h owner=%0d active=%b err=%b want all 0",
               bus.gnt, bus.tx_start, bus.tx_data, bus.owner, bus.active, bus.timeout_err);
    end
    srst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.active !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got active=%b want 0", bus.active);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [3:0] exp_gnt;
    bus.req      = 4'b1111;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int n = 0; n < 5; n++) begin
      exp_gnt = 4'b0001 << (n % 4);
      wait_gnt(cyc);
      total++;
      if (cyc < 0 || bus.gnt !== exp_gnt || bus.tx_data !== 8'h10 + 8'(n % 4)) begin
        bad++;
        $display("FAIL rr_grant%0d: got gnt=%b data=%h cyc=%0d want gnt=%b data=%h",
                 n, bus.gnt, bus.tx_data, cyc, exp_gnt, 8'h10 + 8'(n % 4));
      end
      total++;
      if (bus.tx_start !== 1'b0) begin
        bad++;
        $display("FAIL rr_gap%0d: got tx_start=%b want 0", n, bus.tx_start);
      end
      if (n == 4) bus.req = 4'b0000;
      ack_xfer();
    end
  endtask

  task automatic test_single();
    int cyc;
    @(negedge clk);
    bus.req      = 4'b0100;
    bus.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    wait_gnt(cyc);
    total++;
    if (cyc < 0 || bus.gnt !== 4'b0100 || bus.tx_data !== 8'hA5 || bus.owner !== 2'd2) begin
      bad++;
      $display("FAIL single_grant: got gnt=%b data=%h owner=%0d cyc=%0d want gnt=0100 data=a5 owner=2",
               bus.gnt, bus.tx_data, bus.owner, cyc);
    end
    total++;
    if (bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL single_start_load: got %b want 0", bus.tx_start);
    end
    bus.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.tx_start !== 1'b1 || bus.gnt !== 4'b0000) begin
        bad++;
        $display("FAIL single_start_hold%0d: got start=%b gnt=%b want start=1 gnt=0000",
                 i, bus.tx_start, bus.gnt);
      end
    end
    bus.tx_busy = 1'b1;
    @(negedge clk);
    total++;
    if (bus.tx_start !== 1'b0 || bus.active !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_drop: got start=%b active=%b want start=0 active=1",
               bus.tx_start, bus.active);
    end
    repeat (49) @(negedge clk);
    total++;
    if (bus.tx_data !== 8'hA5 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL single_data_stable: got data=%h err=%b want data=a5 err=0",
               bus.tx_data, bus.timeout_err);
    end
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    total++;
    if (bus.active !== 1'b1) begin
      bad++;
      $display("FAIL single_done_gap: got active=%b want 1", bus.active);
    end
    @(negedge clk);
    total++;
    if (bus.active !== 1'b0 || bus.owner !== 2'd2) begin
      bad++;
      $display("FAIL single_idle: got active=%b owner=%0d want active=0 owner=2",
               bus.active, bus.owner);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bus.req      = 4'b0011;
    bus.req_data = {8'h00, 8'h00, 8'h31, 8'h30};
    wait_gnt(cyc);
    total++;
    if (cyc < 0 || bus.gnt !== 4'b0001 || bus.tx_data !== 8'h30) begin
      bad++;
      $display("FAIL wrap_first: got gnt=%b data=%h want gnt=0001 data=30", bus.gnt, bus.tx_data);
    end
    bus.req = 4'b0010;
    ack_xfer();
    wait_gnt(cyc);
    total++;
    if (cyc < 0 || bus.gnt !== 4'b0010 || bus.tx_data !== 8'h31) begin
      bad++;
      $display("FAIL wrap_second: got gnt=%b data=%h want gnt=0010 data=31", bus.gnt, bus.tx_data);
    end
    bus.req = 4'b0000;
    ack_xfer();
  endtask

  task automatic test_busy_missed();
    int cyc;
    bus.req      = 4'b1000;
    bus.req_data = {8'h5C, 8'h00, 8'h00, 8'h00};
    wait_gnt(cyc);
    total++;
    if (cyc < 0 || bus.gnt !== 4'b1000) begin
      bad++;
      $display("FAIL missed_grant: got gnt=%b want 1000", bus.gnt);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    total++;
    if (bus.tx_start !== 1'b0 || bus.active !== 1'b1 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL missed_done: got start=%b active=%b err=%b want start=0 active=1 err=0",
               bus.tx_start, bus.active, bus.timeout_err);
    end
    @(negedge clk);
    total++;
    if (bus.active !== 1'b0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL missed_idle: got active=%b err=%b want active=0 err=0", bus.active, bus.timeout_err);
    end
    bus.req      = 4'b1111;
    bus.req_data = {8'h63, 8'h62, 8'h61, 8'h60};
    wait_gnt(cyc);
    total++;
    if (cyc < 0 || bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL missed_ptr_adv: got gnt=%b want 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    ack_xfer();
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.req      = 4'b0010;
    bus.req_data = {8'h00, 8'h00, 8'h71, 8'h70};
    wait_gnt(cyc);
    total++;
    if (cyc < 0 || bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin
      bad++;
      $display("FAIL rmid_grant: got gnt=%b owner=%0d want gnt=0010 owner=1", bus.gnt, bus.owner);
    end
    bus.req = 4'b0001;
    @(negedge clk);
    bus.tx_busy = 1'b1;
    @(negedge clk);
    srst = 1'b1;
    #1;
    total++;
    if (bus.tx_start !== 1'b0 || bus.active !== 1'b0 || bus.gnt !== 4'b0000 || bus.owner !== 2'd0) begin
      bad++;
      $display("FAIL rmid_async: got start=%b active=%b gnt=%b owner=%0d want all 0",
               bus.tx_start, bus.active, bus.gnt, bus.owner);
    end
    @(negedge clk);
    bus.tx_busy = 1'b0;
    srst        = 1'b0;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0001 || bus.tx_data !== 8'h70) begin
      bad++;
      $display("FAIL rmid_regrant: got gnt=%b data=%h want gnt=0001 data=70", bus.gnt, bus.tx_data);
    end
    bus.req = 4'b0000;
    ack_xfer();
  endtask

  task automatic test_timeout();
    int cyc;
    int err_first;
    int err_cnt;
    logic start_k20;
    logic start_k21;
    logic active_k22;
    bus_t.req      = 4'b0010;
    bus_t.req_data = {8'h00, 8'h88, 8'h77, 8'h00};
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus_t.gnt != 4'b0000) begin
        cyc = i;
        break;
      end
    end
    total++;
    if (cyc < 0 || bus_t.gnt !== 4'b0010 || bus_t.tx_data !== 8'h77) begin
      bad++;
      $display("FAIL to_grant: got gnt=%b data=%h want gnt=0010 data=77", bus_t.gnt, bus_t.tx_data);
    end
    bus_t.req  = 4'b0100;
    err_first  = -1;
    err_cnt    = 0;
    start_k20  = 1'b0;
    start_k21  = 1'b1;
    active_k22 = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (bus_t.timeout_err === 1'b1) begin
        err_cnt++;
        if (err_first < 0) err_first = k;
      end
      if (k == 20) start_k20 = bus_t.tx_start;
      if (k == 21) start_k21 = bus_t.tx_start;
      if (k == 22) active_k22 = bus_t.active;
    end
    total++;
    if (err_first != 21 || err_cnt != 1) begin
      bad++;
      $display("FAIL to_pulse: got first=%0d count=%0d want first=21 count=1", err_first, err_cnt);
    end
    total++;
    if (start_k20 !== 1'b1 || start_k21 !== 1'b0 || active_k22 !== 1'b0) begin
      bad++;
      $display("FAIL to_drop: got start20=%b start21=%b active22=%b want 1 0 0",
               start_k20, start_k21, active_k22);
    end
    @(negedge clk);
    total++;
    if (bus_t.gnt !== 4'b0100 || bus_t.tx_data !== 8'h88) begin
      bad++;
      $display("FAIL to_next: got gnt=%b data=%h want gnt=0100 data=88", bus_t.gnt, bus_t.tx_data);
    end
    bus_t.req = 4'b0000;
    @(negedge clk);
    bus_t.tx_busy = 1'b1;
    @(negedge clk);
    bus_t.tx_busy = 1'b0;
    bus_t.tx_done = 1'b1;
    @(negedge clk);
    bus_t.tx_done = 1'b0;
    @(negedge clk);
    total++;
    if (bus_t.active !== 1'b0 || bus_t.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_next_done: got active=%b err=%b want active=0 err=0",
               bus_t.active, bus_t.timeout_err);
    end
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    srst             = 1'b1;
    bus.req          = '0;
    bus.req_data     = '0;
    bus.tx_busy      = 1'b0;
    bus.tx_done      = 1'b0;
    bus_t.req        = '0;
    bus_t.req_data   = '0;
    bus_t.tx_busy    = 1'b0;
    bus_t.tx_done    = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_busy_missed();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
